// File: rtl/imm_extract_if.sv
// rtl/imm_extract_if.sv - handshake bundle between instruction source, imm_extract and signext consumer
//
// Purpose: groups the upstream instruction handshake and the downstream
// decoded-immediate handshake of imm_extract.
// Signals:
//   in_valid / in_ready       upstream handshake (in_ready driven by imm_extract)
//   in_instr [31:0]           RV32I instruction word
//   in_pc    [DATA_WIDTH-1:0] PC of in_instr
//   out_valid / out_ready     downstream handshake (out_ready driven by consumer)
//   out_unextended_data       packed immediate, right-aligned, zero above field
//   out_sx_op [2:0]           extension selector for signext
//   out_pc                    PC carried with the result
//   out_illegal               unrecognised opcode flag
// Modports: master = instruction source / consumer side, slave = imm_extract.

interface imm_extract_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [DATA_WIDTH-1:0] in_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_unextended_data;
    logic [2:0]            out_sx_op;
    logic [DATA_WIDTH-1:0] out_pc;
    logic                  out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_unextended_data, out_sx_op, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_unextended_data, out_sx_op, out_pc, out_illegal
    );
endinterface

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - RV32I immediate extractor with output register and skid buffer
//
// Purpose: decodes the immediate field of an RV32I instruction into a
// right-aligned, zero-padded value plus the sign-extension selector for the
// downstream signext block. One cycle of latency, full throughput, and a
// registered in_ready backed by one skid entry.
// Ports:
//   clk    single clock, all state updates on rising edge
//   rst_n  synchronous active-low reset
//   flush  synchronous pipeline kill (drops all held and incoming entries)
//   bus    imm_extract_if.slave handshake bundle

module imm_extract #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_extract_if.slave  bus
);

    generate
        if (DATA_WIDTH < 32) begin : g_width_check
            $error("imm_extract: DATA_WIDTH must be >= 32");
        end
    endgenerate

    localparam logic [2:0] SX_1100 = 3'd0;
    localparam logic [2:0] SX_1300 = 3'd1;
    localparam logic [2:0] SX_2100 = 3'd2;
    localparam logic [2:0] SX_PASS = 3'd3;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [31:0]           imm32;
    logic [DATA_WIDTH-1:0] dec_data;
    logic [2:0]            dec_sx;
    logic                  dec_ill;

    logic [DATA_WIDTH-1:0] out_data_q, out_pc_q, skid_data_q, skid_pc_q;
    logic [2:0]            out_sx_q, skid_sx_q;
    logic                  out_ill_q, skid_ill_q;
    logic                  in_ready_q;

    logic accept, xfer;
    logic load_out_in, load_out_skid, load_skid;

    // Immediate decode of the word currently on the input
    always_comb begin
        imm32   = 32'd0;
        dec_sx  = SX_PASS;
        dec_ill = 1'b0;
        case (bus.in_instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                imm32  = {20'd0, bus.in_instr[31:20]};
                dec_sx = SX_1100;
            end
            OPC_STORE: begin
                imm32  = {20'd0, bus.in_instr[31:25], bus.in_instr[11:7]};
                dec_sx = SX_1100;
            end
            OPC_BRANCH: begin
                imm32  = {19'd0, bus.in_instr[31], bus.in_instr[7],
                          bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
                dec_sx = SX_1300;
            end
            OPC_JAL: begin
                imm32  = {11'd0, bus.in_instr[31], bus.in_instr[19:12],
                          bus.in_instr[20], bus.in_instr[30:21], 1'b0};
                dec_sx = SX_2100;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32  = {bus.in_instr[31:12], 12'd0};
                dec_sx = SX_PASS;
            end
            OPC_OP: begin
                imm32  = 32'd0;
                dec_sx = SX_PASS;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
        dec_data = DATA_WIDTH'(imm32);
    end

    assign accept = bus.in_valid && in_ready_q;
    assign xfer   = (state != EMPTY) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_out_in = 1'b1;
                    state_n     = ONE;
                end
            end
            ONE: begin
                if (accept && !xfer) begin
                    load_skid = 1'b1;
                    state_n   = FULL;
                end else if (!accept && xfer) begin
                    state_n = EMPTY;
                end else if (accept && xfer) begin
                    load_out_in = 1'b1;
                end
            end
            FULL: begin
                if (xfer) begin
                    load_out_skid = 1'b1;
                    state_n       = ONE;
                end
            end
            default: state_n = EMPTY;
        endcase
        // Flush wins over everything; held entries are simply abandoned
        if (flush) begin
            state_n       = EMPTY;
            load_out_in   = 1'b0;
            load_out_skid = 1'b0;
            load_skid     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_pc_q    <= '0;
            out_sx_q    <= SX_PASS;
            out_ill_q   <= 1'b0;
            skid_data_q <= '0;
            skid_pc_q   <= '0;
            skid_sx_q   <= SX_PASS;
            skid_ill_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            // Registered ready: looks at next state so no path from out_ready
            in_ready_q <= (state_n != FULL);
            if (load_out_in) begin
                out_data_q <= dec_data;
                out_pc_q   <= bus.in_pc;
                out_sx_q   <= dec_sx;
                out_ill_q  <= dec_ill;
            end else if (load_out_skid) begin
                out_data_q <= skid_data_q;
                out_pc_q   <= skid_pc_q;
                out_sx_q   <= skid_sx_q;
                out_ill_q  <= skid_ill_q;
            end
            if (load_skid) begin
                skid_data_q <= dec_data;
                skid_pc_q   <= bus.in_pc;
                skid_sx_q   <= dec_sx;
                skid_ill_q  <= dec_ill;
            end
        end
    end

    assign bus.in_ready            = in_ready_q;
    assign bus.out_valid           = (state != EMPTY);
    assign bus.out_unextended_data = out_data_q;
    assign bus.out_pc              = out_pc_q;
    assign bus.out_sx_op           = out_sx_q;
    assign bus.out_illegal         = out_ill_q;

endmodule

// File: tb/tb_imm_extract.sv
// tb/tb_imm_extract.sv - scoreboard testbench for imm_extract

module tb_imm_extract;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   ready_mode;   // 0: hold low, 1: hold high, 2: random

    imm_extract_if #(.DATA_WIDTH(32)) bus ();

    imm_extract #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  sx;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: immediate assembled from the ISA field positions by arithmetic
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        e.data = 32'd0;
        e.sx   = 3'd3;
        e.ill  = 1'b0;
        e.pc   = pc;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: begin
                e.data = i >> 20;
                e.sx   = 3'd0;
            end
            7'h23: begin
                e.data = ((i >> 25) << 5) + ((i >> 7) % 32);
                e.sx   = 3'd0;
            end
            7'h63: begin
                e.data = (32'(i[31]) << 12) + (32'(i[7]) << 11)
                       + (((i >> 25) % 64) << 5) + (((i >> 8) % 16) << 1);
                e.sx   = 3'd1;
            end
            7'h6F: begin
                e.data = (32'(i[31]) << 20) + (((i >> 12) % 256) << 12)
                       + (32'(i[20]) << 11) + (((i >> 21) % 1024) << 1);
                e.sx   = 3'd2;
            end
            7'h37, 7'h17: e.data = (i >> 12) << 12;
            7'h33: e.data = 32'd0;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Downstream ready generator
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops expectations on every output transfer and checks stalls hold
    logic        hold_valid = 1'b0;
    logic [31:0] h_data, h_pc;
    logic [2:0]  h_sx;
    logic        h_ill;

    always @(negedge clk) begin
        if (!rst_n || flush) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_data", bus.out_unextended_data, h_data);
                chk("stall_pc", bus.out_pc, h_pc);
                chk("stall_sx", 32'(bus.out_sx_op), 32'(h_sx));
                chk("stall_ill", 32'(bus.out_illegal), 32'(h_ill));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", bus.out_unextended_data, e.data);
                    chk("out_sx_op", 32'(bus.out_sx_op), 32'(e.sx));
                    chk("out_illegal", 32'(bus.out_illegal), 32'(e.ill));
                    chk("out_pc", bus.out_pc, e.pc);
                end
            end
            hold_valid = bus.out_valid && !bus.out_ready;
            h_data = bus.out_unextended_data;
            h_pc   = bus.out_pc;
            h_sx   = bus.out_sx_op;
            h_ill  = bus.out_illegal;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction until accepted; expectation pushed on acceptance
    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        bus.in_pc    = pc;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(model(ins, pc));
                step();
                bus.in_valid = 1'b0;
                return;
            end
            step();
        end
        chk("send_timeout", 32'd1, 32'd0);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        ready_mode = 1;
        for (int n = 0; n < 100 && sb.size() != 0; n++) step();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_out(input string name, input logic [31:0] data, input logic [2:0] sx,
                             input logic ill);
        @(negedge clk);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, "_data"}, bus.out_unextended_data, data);
        chk({name, "_sx"}, 32'(bus.out_sx_op), 32'(sx));
        chk({name, "_ill"}, 32'(bus.out_illegal), 32'(ill));
        step();
    endtask

    localparam logic [6:0] OPCODES [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63,
                                            7'h6F, 7'h37, 7'h17, 7'h33, 7'h7F};

    initial begin
        ready_mode   = 1;
        rst_n        = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hFFF00093;
        bus.in_pc    = 32'h0000_0040;
        bus.out_ready = 1'b1;

        // Reset held two cycles with a valid input present
        step();
        step();
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", bus.out_unextended_data, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_sx", 32'(bus.out_sx_op), 32'd3);
        chk("rst_pc", bus.out_pc, 32'd0);
        chk("rst_ill", 32'(bus.out_illegal), 32'd0);
        step();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("post_rst_no_capture", 32'(bus.out_valid), 32'd0);
        step();

        // Directed decodes
        send(32'hFFF00093, 32'h100);
        check_out("addi", 32'h00000FFF, 3'd0, 1'b0);
        send(32'hFE000EE3, 32'h104);
        check_out("beq", 32'h00001FFC, 3'd1, 1'b0);
        send(32'h123450B7, 32'h108);
        check_out("lui", 32'h12345000, 3'd3, 1'b0);
        send(32'h0000007F, 32'h10C);
        check_out("illegal", 32'h00000000, 3'd3, 1'b1);
        drain();

        // Backpressure: two accepted, third blocked, then released in order
        ready_mode = 0;
        step();
        send(32'h00A00513, 32'h200);
        send(32'h0040006F, 32'h204);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00112223;
        bus.in_pc    = 32'h208;
        @(negedge clk);
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        step();
        ready_mode = 1;
        send(32'h00112223, 32'h208);
        drain();

        // Flush while FULL with a new input offered on the same edge
        ready_mode = 0;
        step();
        send(32'h00100093, 32'h300);
        send(32'h00200113, 32'h304);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00300193;
        bus.in_pc    = 32'h308;
        flush = 1'b1;
        @(negedge clk);
        sb.delete();
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        ready_mode = 1;
        step();
        step();
        @(negedge clk);
        chk("flush_no_stale", 32'(bus.out_valid), 32'd0);
        step();

        // Reset mid-stall discards held entries
        ready_mode = 0;
        step();
        send(32'h00400213, 32'h400);
        send(32'h00500293, 32'h404);
        rst_n = 1'b0;
        @(negedge clk);
        sb.delete();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_mid_data", bus.out_unextended_data, 32'd0);
        step();

        // Random stream with random backpressure and occasional flushes
        ready_mode = 2;
        for (int k = 0; k < 1000; k++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 9) != 0)
                ins[6:0] = OPCODES[$urandom_range(0, 9)];
            if ($urandom_range(0, 3) == 0) step();
            if ($urandom_range(0, 199) == 0) begin
                flush = 1'b1;
                @(negedge clk);
                sb.delete();
                step();
                flush = 1'b0;
            end
            send(ins, $urandom);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_extract.md
IMM_EXTRACT -- requirements
Module: imm_extract

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, datapath width; the block SHALL support only DATA_WIDTH >= 32.
REQ-002 clk  in  1  single clock; every register SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset; synchronous and active-low, sampled on rising clk.
REQ-004 flush  in  1  synchronous pipeline kill.
REQ-005 in_valid  in  1  upstream instruction valid.
REQ-006 in_ready  out  1  block can accept; registered output.
REQ-007 in_instr  in  32  RV32I instruction word.
REQ-008 in_pc  in  DATA_WIDTH  PC of in_instr.
REQ-009 out_valid  out  1  decoded result valid.
REQ-010 out_ready  in  1  downstream (signext consumer) accepts.
REQ-011 out_unextended_data  out  DATA_WIDTH  packed immediate, right-aligned, zero above field width; drives signext.unextended_data.
REQ-012 out_sx_op  out  3  extension selector; drives signext.sx_op.
REQ-013 out_pc  out  DATA_WIDTH  PC carried with result.
REQ-014 out_illegal  out  1  unrecognised opcode.

Function
REQ-015 Opcode decode SHALL use in_instr[6:0]; the encodings below SHALL match the isa_shared constants.
REQ-016 LOAD 0000011, OP-IMM 0010011, JALR 1100111: data = instr[31:20] (12 bits), sx_op = SX_1100 (3'd0).
REQ-017 STORE 0100011: data = {instr[31:25], instr[11:7]} (12 bits), sx_op = SX_1100.
REQ-018 BRANCH 1100011: data = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} (13 bits), sx_op = SX_1300 (3'd1).
REQ-019 JAL 1101111: data = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} (21 bits), sx_op = SX_2100 (3'd2).
REQ-020 LUI 0110111 and AUIPC 0010111: data = {instr[31:12], 12'b0}, sx_op = SX_PASS (3'd3, no extension).
REQ-021 OP 0110011: data = 0, sx_op = SX_PASS, illegal = 0.
REQ-022 Any other opcode: data = 0, sx_op = SX_PASS, illegal = 1; the entry SHALL still flow through the handshake.
REQ-023 A transfer SHALL occur on a clk edge where valid && ready on the respective side.
REQ-024 Latency SHALL be 1 cycle: an instruction accepted at edge N appears on out_* after edge N, unless entries ahead of it are still held.
REQ-025 Sustained throughput SHALL be 1 per cycle while out_ready = 1.
REQ-026 Buffering: output register plus one skid register. States: EMPTY, ONE (output valid), FULL (output and skid valid).
REQ-027 EMPTY: on accept -> ONE.
REQ-028 ONE: accept without output transfer -> FULL; output transfer without accept -> EMPTY; accept and transfer together -> ONE, with the new entry loaded into the output register.
REQ-029 FULL: on output transfer, the skid entry moves to the output register -> ONE; in_ready = 0 throughout FULL.
REQ-030 in_ready SHALL equal 1 in EMPTY and ONE, registered (no combinational path from out_ready).
REQ-031 While out_valid = 1 and out_ready = 0, all out_* SHALL hold stable.
REQ-032 Entries SHALL leave in acceptance order, with no loss or duplication.
REQ-033 flush = 1 at an edge: state -> EMPTY, any input presented that cycle is discarded, out_valid = 0 and in_ready = 1 after the edge; flush SHALL take priority over accept and transfer.
REQ-034 Unused upper bits of out_unextended_data (DATA_WIDTH > 32) SHALL be 0.

Reset
REQ-035 rst_n = 0 at an edge: state -> EMPTY, out_valid = 0, in_ready = 1, out_unextended_data = 0, out_pc = 0, out_sx_op = 3'd3, out_illegal = 0.
REQ-036 Reset SHALL override flush and handshakes, and an in-flight entry SHALL be discarded even mid-stall (reset mid-operation).

Verification
REQ-037 Reset: rst_n = 0 for 2 cycles with in_valid = 1 -> out_valid = 0, out_unextended_data = 0x00000000, in_ready = 1; no entry captured.
REQ-038 ADDI x1,x0,-1 (0xFFF00093), out_ready = 1 -> next cycle out_valid = 1, data = 0x00000FFF, sx_op = 3'd0, illegal = 0; signext output = 0xFFFFFFFF.
REQ-039 BEQ x0,x0,-4 (0xFE000EE3) -> data = 0x00001FFC, sx_op = 3'd1; LUI x1,0x12345 (0x123450B7) -> data = 0x12345000, sx_op = 3'd3.
REQ-040 Backpressure: 3 back-to-back instructions with out_ready = 0 -> in_ready = 0 after 2 accepts; on releasing out_ready, all 3 exit in order, with no loss or duplication.
REQ-041 Flush in FULL, with in_valid = 1 on the same edge -> next cycle out_valid = 0, in_ready = 1; no stale entry ever appears.
REQ-042 Opcode 0x0000007F -> out_illegal = 1, data = 0, sx_op = 3'd3; a random 1000-instruction stream with random out_ready matches a reference-model scoreboard.
